// File: rtl/qpi_mi_arbiter_if.sv
// Bus bundles for qpi_mi_arbiter: the upstream per-port request/data bus
// (vectors flattened, port i in slice i) and the downstream mi_* controller bus.
interface qpi_mi_up_if #(
  parameter int N_PORTS    = 2,
  parameter int N_CS       = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 7,
  parameter int DATA_WIDTH = 32
);
  logic [N_PORTS*N_CS-1:0]       u_addr_cs;
  logic [N_PORTS*ADDR_WIDTH-1:0] u_addr;
  logic [N_PORTS*LEN_WIDTH-1:0]  u_len;
  logic [N_PORTS-1:0]            u_rw;
  logic [N_PORTS-1:0]            u_valid;
  logic [N_PORTS-1:0]            u_ready;
  logic [N_PORTS*DATA_WIDTH-1:0] u_wdata;
  logic [N_PORTS-1:0]            u_wack;
  logic [N_PORTS-1:0]            u_wlast;
  logic [DATA_WIDTH-1:0]         u_rdata;
  logic [N_PORTS-1:0]            u_rstb;
  logic [N_PORTS-1:0]            u_rlast;

  modport master (
    output u_addr_cs, u_addr, u_len, u_rw, u_valid, u_wdata,
    input  u_ready, u_wack, u_wlast, u_rdata, u_rstb, u_rlast
  );

  modport slave (
    input  u_addr_cs, u_addr, u_len, u_rw, u_valid, u_wdata,
    output u_ready, u_wack, u_wlast, u_rdata, u_rstb, u_rlast
  );
endinterface

interface qpi_mi_dn_if #(
  parameter int N_CS       = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 7,
  parameter int DATA_WIDTH = 32
);
  logic [N_CS-1:0]       mi_addr_cs;
  logic [ADDR_WIDTH-1:0] mi_addr;
  logic [LEN_WIDTH-1:0]  mi_len;
  logic                  mi_rw;
  logic                  mi_valid;
  logic                  mi_ready;
  logic [DATA_WIDTH-1:0] mi_wdata;
  logic                  mi_wack;
  logic                  mi_wlast;
  logic [DATA_WIDTH-1:0] mi_rdata;
  logic                  mi_rstb;
  logic                  mi_rlast;

  modport master (
    output mi_addr_cs, mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
    input  mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
  );

  modport slave (
    input  mi_addr_cs, mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
    output mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
  );
endinterface

// File: rtl/qpi_mi_arbiter.sv
// Round-robin burst arbiter sharing one qpi_memctrl mi_* port among N_PORTS masters.
// Define QPI_MI_ARB_PRIO0_EN to give port 0 strict priority over the round-robin ports.
module qpi_mi_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int N_CS       = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  qpi_mi_up_if.slave  up,
  qpi_mi_dn_if.master dn
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_owner;
  logic          r_owner_rw;
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_winner;
  logic [PW-1:0] w_owner_inc;
  logic [PW-1:0] w_rr_next;
  logic          w_any_valid;
  logic          w_burst_done;

  assign w_any_valid  = |up.u_valid;
  assign w_burst_done = (r_state == DATA) &&
                        (r_owner_rw ? (dn.mi_rstb & dn.mi_rlast)
                                    : (dn.mi_wack & dn.mi_wlast));
  assign w_owner_inc  = (r_owner == PW'(N_PORTS - 1)) ? '0 : r_owner + PW'(1);

`ifdef QPI_MI_ARB_PRIO0_EN
  // Port 0 only ever wins through its priority path, so its bursts leave the pointer alone.
  assign w_rr_next = (r_owner == '0) ? r_rr_ptr : w_owner_inc;
`else
  assign w_rr_next = w_owner_inc;
`endif

  // Walk from the farthest port back to rr_ptr so the closest requester at/after it wins.
  always_comb begin : winner_sel
    int idx;
    w_winner = '0;
    idx      = 0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (up.u_valid[PW'(idx)]) w_winner = PW'(idx);
    end
`ifdef QPI_MI_ARB_PRIO0_EN
    if (up.u_valid[0]) w_winner = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_owner_rw <= 1'b0;
      r_rr_ptr   <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && w_any_valid) begin
        r_owner    <= w_winner;
        r_owner_rw <= up.u_rw[w_winner];
      end
      if (w_burst_done) r_rr_ptr <= w_rr_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_valid) w_next_state = ISSUE;
      ISSUE:   if (dn.mi_ready) w_next_state = DATA;
      DATA:    if (w_burst_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request fields and write data always follow the current owner's slice.
  always_comb begin
    dn.mi_addr_cs = up.u_addr_cs[0 +: N_CS];
    dn.mi_addr    = up.u_addr[0 +: ADDR_WIDTH];
    dn.mi_len     = up.u_len[0 +: LEN_WIDTH];
    dn.mi_rw      = up.u_rw[0];
    dn.mi_wdata   = up.u_wdata[0 +: DATA_WIDTH];
    for (int p = 1; p < N_PORTS; p++) begin
      if (r_owner == PW'(p)) begin
        dn.mi_addr_cs = up.u_addr_cs[p*N_CS +: N_CS];
        dn.mi_addr    = up.u_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        dn.mi_len     = up.u_len[p*LEN_WIDTH +: LEN_WIDTH];
        dn.mi_rw      = up.u_rw[p];
        dn.mi_wdata   = up.u_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Strobes of the type that does not match the burst direction are dropped here.
  always_comb begin
    dn.mi_valid = 1'b0;
    up.u_ready  = '0;
    up.u_wack   = '0;
    up.u_wlast  = '0;
    up.u_rstb   = '0;
    up.u_rlast  = '0;
    up.u_rdata  = dn.mi_rdata;
    case (r_state)
      ISSUE: begin
        dn.mi_valid         = 1'b1;
        up.u_ready[r_owner] = dn.mi_ready;
      end
      DATA: begin
        if (r_owner_rw) begin
          up.u_rstb[r_owner]  = dn.mi_rstb;
          up.u_rlast[r_owner] = dn.mi_rlast;
        end else begin
          up.u_wack[r_owner]  = dn.mi_wack;
          up.u_wlast[r_owner] = dn.mi_wlast;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qpi_mi_arbiter.sv
// Directed self-checking bench for qpi_mi_arbiter (3 ports); the bench plays the controller.
// Expected grant orders follow QPI_MI_ARB_PRIO0_EN when the build defines it.
module tb_qpi_mi_arbiter;

  localparam int NP  = 3;
  localparam int NCS = 2;
  localparam int AW  = 24;
  localparam int LW  = 7;
  localparam int DW  = 32;

`ifdef QPI_MI_ARB_PRIO0_EN
  localparam int T5_WIN = 0;
  int t3Order[4] = '{0, 0, 0, 0};
`else
  localparam int T5_WIN = 2;
  int t3Order[4] = '{0, 1, 0, 1};
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  qpi_mi_up_if #(.N_PORTS(NP), .N_CS(NCS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) upIf ();
  qpi_mi_dn_if #(.N_CS(NCS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) dnIf ();

  qpi_mi_arbiter #(
    .N_PORTS(NP), .N_CS(NCS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .up   (upIf),
    .dn   (dnIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int port, input logic [NCS-1:0] cs, input logic [AW-1:0] addr,
                               input logic [LW-1:0] len, input logic rw);
    upIf.u_addr_cs[port*NCS +: NCS] = cs;
    upIf.u_addr[port*AW +: AW]      = addr;
    upIf.u_len[port*LW +: LW]       = len;
    upIf.u_rw[port]                 = rw;
    upIf.u_valid[port]              = 1'b1;
  endtask

  // Called in IDLE with requests posted; returns one cycle later in ISSUE.
  task automatic issueCheck(input int expPort, input string tag);
    #1;
    checkOutput({tag, "_idle_mivalid"}, 64'(dnIf.mi_valid), 64'd0);
    tick;
    checkOutput({tag, "_mivalid"}, 64'(dnIf.mi_valid), 64'd1);
    checkOutput({tag, "_ready"}, 64'(upIf.u_ready), 64'(1) << expPort);
  endtask

  // Every third cycle is a stall carrying spurious strobes of the opposite type.
  task automatic dataPhase(input int port, input logic rw, input int nBeats, input string tag);
    int beat, cyc, strobes, bad, dataErr, lastAt;
    logic stall;
    logic [NP-1:0] own;
    logic [DW-1:0] expData;
    beat = 0; cyc = 0; strobes = 0; bad = 0; dataErr = 0; lastAt = -1;
    own = NP'(1) << port;
    while (beat < nBeats) begin
      stall   = (cyc % 3 == 2);
      expData = rw ? (32'h1000_0000 + 32'(beat)) : (32'h0001_0203 + 32'(beat) * 32'h0404_0404);
      for (int p = 0; p < NP; p++)
        upIf.u_wdata[p*DW +: DW] = (p == port) ? expData : (32'hDEAD_0000 + 32'(p));
      dnIf.mi_rdata = expData;
      dnIf.mi_rstb  = rw ? !stall : stall;
      dnIf.mi_rlast = rw ? (!stall && beat == nBeats - 1) : stall;
      dnIf.mi_wack  = rw ? stall : !stall;
      dnIf.mi_wlast = rw ? stall : (!stall && beat == nBeats - 1);
      #1;
      if (rw) begin
        if (upIf.u_rstb[port] === 1'b1) strobes++;
        if (upIf.u_rlast[port] === 1'b1) lastAt = beat;
        if ((((upIf.u_rstb | upIf.u_rlast) & ~own) != '0) || ((upIf.u_wack | upIf.u_wlast) != '0)) bad++;
        if (!stall && upIf.u_rdata !== expData) dataErr++;
      end else begin
        if (upIf.u_wack[port] === 1'b1) strobes++;
        if (upIf.u_wlast[port] === 1'b1) lastAt = beat;
        if ((((upIf.u_wack | upIf.u_wlast) & ~own) != '0) || ((upIf.u_rstb | upIf.u_rlast) != '0)) bad++;
        if (!stall && dnIf.mi_wdata !== expData) dataErr++;
      end
      if (dnIf.mi_valid !== 1'b0 || upIf.u_ready != '0) bad++;
      tick;
      if (!stall) beat++;
      cyc++;
    end
    dnIf.mi_rstb  = 1'b0;
    dnIf.mi_rlast = 1'b0;
    dnIf.mi_wack  = 1'b0;
    dnIf.mi_wlast = 1'b0;
    checkOutput({tag, "_beats"}, 64'(strobes), 64'(nBeats));
    checkOutput({tag, "_last_beat"}, 64'(lastAt), 64'(nBeats - 1));
    checkOutput({tag, "_stray_strobes"}, 64'(bad), 64'd0);
    checkOutput({tag, "_data_errors"}, 64'(dataErr), 64'd0);
  endtask

  initial begin
    string tag;
    int    exp;

    // Reset with every input active: nothing may leak out while held in IDLE.
    rst_n          = 1'b0;
    upIf.u_addr_cs = {2'b01, 2'b01, 2'b01};
    upIf.u_addr    = {24'h777777, 24'h555555, 24'hABCDEF};
    upIf.u_len     = {7'd9, 7'd10, 7'd5};
    upIf.u_rw      = '0;
    upIf.u_valid   = 3'b111;
    upIf.u_wdata   = '0;
    dnIf.mi_ready  = 1'b1;
    dnIf.mi_wack   = 1'b1;
    dnIf.mi_wlast  = 1'b1;
    dnIf.mi_rstb   = 1'b1;
    dnIf.mi_rlast  = 1'b1;
    dnIf.mi_rdata  = 32'hA5A5_5A5A;
    tick;
    tick;
    #1;
    checkOutput("rst_mivalid", 64'(dnIf.mi_valid), 64'd0);
    checkOutput("rst_ready", 64'(upIf.u_ready), 64'd0);
    checkOutput("rst_strobes", 64'(upIf.u_rstb | upIf.u_rlast | upIf.u_wack | upIf.u_wlast), 64'd0);
    checkOutput("rst_rdata", 64'(upIf.u_rdata), 64'h0000_0000_A5A5_5A5A);
    rst_n         = 1'b1;
    upIf.u_valid  = '0;
    dnIf.mi_wack  = 1'b0;
    dnIf.mi_wlast = 1'b0;
    dnIf.mi_rstb  = 1'b0;
    dnIf.mi_rlast = 1'b0;
    tick;

    // Single port 1 read of 32 words.
    applyStimulus(1, 2'b10, 24'h123456, 7'd31, 1'b1);
    issueCheck(1, "t1");
    checkOutput("t1_addr", 64'(dnIf.mi_addr), 64'h12_3456);
    checkOutput("t1_rw", 64'(dnIf.mi_rw), 64'd1);
    checkOutput("t1_len", 64'(dnIf.mi_len), 64'd31);
    checkOutput("t1_cs", 64'(dnIf.mi_addr_cs), 64'd2);
    tick;
    upIf.u_valid[1] = 1'b0;
    dataPhase(1, 1'b1, 32, "t1");

    // Ports 1 and 2 with rr_ptr at 2: port 2 first, then port 1.
    applyStimulus(1, 2'b01, 24'h100040, 7'd3, 1'b0);
    applyStimulus(2, 2'b10, 24'h200000, 7'd1, 1'b1);
    issueCheck(2, "t4a");
    checkOutput("t4a_addr", 64'(dnIf.mi_addr), 64'h20_0000);
    checkOutput("t4a_len", 64'(dnIf.mi_len), 64'd1);
    tick;
    upIf.u_valid[2] = 1'b0;
    dataPhase(2, 1'b1, 2, "t4a");
    issueCheck(1, "t4b");
    checkOutput("t4b_addr", 64'(dnIf.mi_addr), 64'h10_0040);
    checkOutput("t4b_rw", 64'(dnIf.mi_rw), 64'd0);
    tick;
    upIf.u_valid[1] = 1'b0;
    dataPhase(1, 1'b0, 4, "t4b");

    // Pointer is back at 2: ports 0 and 2 contend, then reset lands mid-read.
    applyStimulus(0, 2'b01, 24'h000500, 7'd7, 1'b1);
    applyStimulus(2, 2'b10, 24'h200800, 7'd7, 1'b1);
    issueCheck(T5_WIN, "t5");
    tick;
    upIf.u_valid  = '0;
    dnIf.mi_rstb  = 1'b1;
    dnIf.mi_rlast = 1'b0;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    checkOutput("t5_rst_mivalid", 64'(dnIf.mi_valid), 64'd0);
    checkOutput("t5_rst_strobes", 64'(upIf.u_rstb | upIf.u_rlast | upIf.u_wack | upIf.u_wlast), 64'd0);
    checkOutput("t5_rst_ready", 64'(upIf.u_ready), 64'd0);
    dnIf.mi_rstb = 1'b0;

    // Ports 0 and 1 request continuously for four bursts.
    applyStimulus(0, 2'b01, 24'h000100, 7'd3, 1'b0);
    applyStimulus(1, 2'b10, 24'h000200, 7'd3, 1'b1);
    for (int g = 0; g < 4; g++) begin
      exp = t3Order[g];
      tag = $sformatf("t3_g%0d", g);
      issueCheck(exp, tag);
      checkOutput({tag, "_addr"}, 64'(dnIf.mi_addr), (exp == 0) ? 64'h100 : 64'h200);
      tick;
      if (g == 3) upIf.u_valid = '0;
      dataPhase(exp, (exp == 1), 4, tag);
    end

    // Port 0 write of 32 incrementing words with spurious read strobes on stalls.
    applyStimulus(0, 2'b01, 24'h003000, 7'd31, 1'b0);
    issueCheck(0, "t2");
    checkOutput("t2_addr", 64'(dnIf.mi_addr), 64'h00_3000);
    checkOutput("t2_rw", 64'(dnIf.mi_rw), 64'd0);
    checkOutput("t2_len", 64'(dnIf.mi_len), 64'd31);
    checkOutput("t2_cs", 64'(dnIf.mi_addr_cs), 64'd1);
    tick;
    upIf.u_valid[0] = 1'b0;
    dataPhase(0, 1'b0, 32, "t2");
    #1;
    checkOutput("end_mivalid", 64'(dnIf.mi_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
